rgb_led_scheduler: RTL and testbench
====================================

RGB_LED_SCHEDULER -- requirements
Module: rgb_led_scheduler

Interface
REQ-001 SHALL expose parameter PRESCALE, default 12000, clk cycles per 1 ms tick.
REQ-002 SHALL expose parameter GAP_MS, default 50, dark-gap length in ms (used only under RGB_GAP_EN).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_valid  input  1  requester A holds a color command.
REQ-006 a_ready  output  1  A's command accepted this cycle when a_valid && a_ready.
REQ-007 a_rgb  input  24  A color, {R[23:16], G[15:8], B[7:0]} duty values.
REQ-008 a_dur_ms  input  16  A display time, ms.
REQ-009 b_valid, b_ready, b_rgb, b_dur_ms  SHALL mirror the A ports for requester B.
REQ-010 red_pwm, green_pwm, blue_pwm  output  1 each  PWM to SB_RGBA_DRV RGB2PWM/RGB0PWM/RGB1PWM.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 grant_b  output  1  owner of the current or most recent command (0 = A, 1 = B).

Function
REQ-013 FSM states SHALL be IDLE, SHOW, GAP; GAP SHALL exist only under RGB_GAP_EN.
REQ-014 In IDLE, x_ready SHALL be high combinationally for exactly one requester: the only valid one, or, if both are valid, the one not equal to grant_b (round-robin); otherwise both low.
REQ-015 Outside IDLE, a_ready and b_ready SHALL be 0; valid inputs SHALL stay pending, never dropped.
REQ-016 On a handshake the block SHALL latch rgb, dur_ms and grant_b, then enter SHOW on the next edge.
REQ-017 dur_ms = 0 SHALL be treated as 1.
REQ-018 The ms prescaler SHALL clear on accept and pulse a tick when it reaches PRESCALE-1, then wrap to 0.
REQ-019 SHOW SHALL last exactly dur*PRESCALE cycles, then go to GAP (macro on) or IDLE (macro off).
REQ-020 GAP SHALL last exactly GAP_MS*PRESCALE cycles with all PWM low, then go to IDLE.
REQ-021 An 8-bit free-running pwm_cnt SHALL be shared by all channels and increment every cycle, wrapping 255->0.
REQ-022 In SHOW, channel output SHALL be (pwm_cnt < duty): duty 0 is never high, duty 255 is high 255/256 cycles.
REQ-023 Outside SHOW, all PWM outputs SHALL be 0.
REQ-024 PWM outputs SHALL be registered and reflect the new color from the first SHOW cycle.
REQ-025 Back-to-back: a valid requester seen in the IDLE cycle after SHOW/GAP SHALL be accepted in that same cycle, giving one IDLE cycle between commands.

Reset
REQ-026 While rst_n = 0: state=IDLE; PWM outputs, busy, grant_b=1 (so A wins the first tie), pwm_cnt, prescaler and latched color all 0.
REQ-027 Reset asserted mid-SHOW or mid-GAP SHALL abort immediately and discard the latched command.
REQ-028 Requesters SHALL re-present the aborted command after reset.

Configuration
REQ-029 Macro RGB_LED_SCHEDULER_GAP_EN defined: the GAP state and GAP_MS SHALL be used.
REQ-030 Macro RGB_LED_SCHEDULER_GAP_EN undefined: SHOW SHALL go directly to IDLE, no GAP logic synthesised, GAP_MS ignored.

Structure
REQ-031 Shared package rgb_led_pkg SHALL hold the FSM state encoding, the 24-bit color field offsets and named color constants (RED=FF0000, GREEN=00FF00, BLUE=0000FF, WHITE=FFFFFF, OFF=000000).
REQ-032 One sub-module rgb_pwm_channel (registered duty compare against shared pwm_cnt, enable input) SHALL be instantiated three times.

Verification (PRESCALE=4, GAP_MS=2)
REQ-033 A only: rgb=FF0000, dur=3 -> a_ready for 1 cycle; red_pwm high 255/256 for 12 cycles; green/blue 0; busy high.
REQ-034 A and B valid together from reset -> A granted first; B is granted at the first IDLE cycle after A's command ends; with both held valid, grants alternate A, B, A.
REQ-035 rgb=800040, dur=0 -> SHOW lasts 4 cycles; per 256-cycle window red high 128 cycles, blue high 64 cycles.
REQ-036 Macro on: after SHOW, all PWM outputs low and busy high for 8 cycles, then IDLE. Macro off: IDLE on the next cycle.
REQ-037 rst_n pulsed low mid-SHOW -> all outputs 0 within the same cycle; after release the next A command is accepted normally.
REQ-038 a_valid held during SHOW -> a_ready stays 0 until IDLE, then the command is accepted once with no duplicate.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// Shared definitions for the RGB LED scheduler: FSM encoding, colour field layout, named colours.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int CH_W      = 8;
    localparam int RED_LSB   = 16;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 0;

    localparam logic [23:0] RGB_RED   = 24'hFF0000;
    localparam logic [23:0] RGB_GREEN = 24'h00FF00;
    localparam logic [23:0] RGB_BLUE  = 24'h0000FF;
    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_OFF   = 24'h000000;

    function automatic logic [CH_W-1:0] duty_of(input logic [23:0] rgb, input int lsb);
        return rgb[lsb +: CH_W];
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: registered compare of duty against the shared counter, one cycle latency.
// No flow control; output is forced low whenever en is low.
module rgb_pwm_channel
    import rgb_led_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [CH_W-1:0] duty,
    input  logic [CH_W-1:0] pwm_cnt,
    output logic            pwm
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= en && (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/rgb_led_scheduler.sv
// Two-requester round-robin colour scheduler driving three PWM channels for dur_ms ms per command.
// Ready only in IDLE (one idle cycle between commands); optional dark gap under RGB_LED_SCHEDULER_GAP_EN.
module rgb_led_scheduler
    import rgb_led_pkg::*;
#(
    parameter int PRESCALE = 12000,
    parameter int GAP_MS   = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [23:0] a_rgb,
    input  logic [15:0] a_dur_ms,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [23:0] b_rgb,
    input  logic [15:0] b_dur_ms,
    output logic        red_pwm,
    output logic        green_pwm,
    output logic        blue_pwm,
    output logic        busy,
    output logic        grant_b
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    state_t          state;
    logic [PW-1:0]   presc;
    logic [15:0]     ms_left;
    logic [23:0]     color;
    logic [CH_W-1:0] pwm_cnt;

    logic        idle;
    logic        accept_a;
    logic        accept_b;
    logic        accept;
    logic [23:0] acc_rgb;
    logic [15:0] acc_dur;
    logic        tick;
    logic        ms_last;
    logic        show_nxt;
    logic [23:0] duty_src;

    // On a tie the requester that did not own the previous command wins.
    assign idle     = (state == ST_IDLE);
    assign a_ready  = idle && a_valid && (!b_valid || grant_b);
    assign b_ready  = idle && b_valid && (!a_valid || !grant_b);
    assign accept_a = a_valid && a_ready;
    assign accept_b = b_valid && b_ready;
    assign accept   = accept_a || accept_b;
    assign acc_rgb  = accept_b ? b_rgb : a_rgb;
    assign acc_dur  = accept_b ? b_dur_ms : a_dur_ms;
    assign busy     = !idle;

    assign tick     = (presc == PRESC_MAX);
    assign ms_last  = tick && (ms_left == 16'd1);

    // Channels register the next-cycle view so the new colour appears in the first SHOW cycle.
    assign show_nxt = accept || ((state == ST_SHOW) && !ms_last);
    assign duty_src = accept ? acc_rgb : color;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + CH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            presc   <= '0;
            ms_left <= '0;
            color   <= '0;
            grant_b <= 1'b1;
        end else begin
            if (accept || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_SHOW;
                        color   <= acc_rgb;
                        grant_b <= accept_b;
                        ms_left <= (acc_dur == 16'd0) ? 16'd1 : acc_dur;
                    end
                end
                ST_SHOW: begin
                    if (ms_last) begin
`ifdef RGB_LED_SCHEDULER_GAP_EN
                        state   <= ST_GAP;
                        ms_left <= 16'(GAP_MS);
`else
                        state   <= ST_IDLE;
`endif
                    end else if (tick) begin
                        ms_left <= ms_left - 16'd1;
                    end
                end
`ifdef RGB_LED_SCHEDULER_GAP_EN
                ST_GAP: begin
                    if (ms_last) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        ms_left <= ms_left - 16'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    rgb_pwm_channel u_red (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (show_nxt),
        .duty    (duty_of(duty_src, RED_LSB)),
        .pwm_cnt (pwm_cnt),
        .pwm     (red_pwm)
    );

    rgb_pwm_channel u_green (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (show_nxt),
        .duty    (duty_of(duty_src, GREEN_LSB)),
        .pwm_cnt (pwm_cnt),
        .pwm     (green_pwm)
    );

    rgb_pwm_channel u_blue (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (show_nxt),
        .duty    (duty_of(duty_src, BLUE_LSB)),
        .pwm_cnt (pwm_cnt),
        .pwm     (blue_pwm)
    );

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Scoreboard bench for rgb_led_scheduler (PRESCALE=4, GAP_MS=2); follows RGB_LED_SCHEDULER_GAP_EN.
module tb_rgb_led_scheduler;
    import rgb_led_pkg::*;

    localparam int P = 4;
    localparam int G = 2;
`ifdef RGB_LED_SCHEDULER_GAP_EN
    localparam int GAP_CYC = G * P;
`else
    localparam int GAP_CYC = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [23:0] a_rgb, b_rgb;
    logic [15:0] a_dur_ms, b_dur_ms;
    logic        red_pwm, green_pwm, blue_pwm, busy, grant_b;

    rgb_led_scheduler #(.PRESCALE(P), .GAP_MS(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rgb(a_rgb), .a_dur_ms(a_dur_ms),
        .b_valid(b_valid), .b_ready(b_ready), .b_rgb(b_rgb), .b_dur_ms(b_dur_ms),
        .red_pwm(red_pwm), .green_pwm(green_pwm), .blue_pwm(blue_pwm),
        .busy(busy), .grant_b(grant_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          owner;
        logic [23:0] rgb;
        int          busy_len;
        int          r_lo, r_hi, g_lo, g_hi, b_lo, b_hi;
        bit          chk_idle;
    } exp_t;

    typedef struct {
        bit          owner;
        logic [23:0] rgb;
        int          busy_len;
        int          red, green, blue;
        int          idle_before;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_count = 0, stray_pwm = 0, both_ready = 0, ready_busy = 0;

    // Counter values seen across n consecutive cycles: how many can be below duty d.
    function automatic int pwm_lo(input int n, input int d);
        int x;
        x = (n % 256) - (256 - d);
        return (n / 256) * d + ((x > 0) ? x : 0);
    endfunction

    function automatic int pwm_hi(input int n, input int d);
        return (n / 256) * d + (((n % 256) < d) ? (n % 256) : d);
    endfunction

    task automatic push_exp(input bit owner, input logic [23:0] rgb, input int dur, input bit chk_idle);
        exp_t e;
        int   n;
        n = ((dur == 0) ? 1 : dur) * P;
        e.owner = owner; e.rgb = rgb; e.busy_len = n + GAP_CYC; e.chk_idle = chk_idle;
        e.r_lo = pwm_lo(n, int'(rgb[23:16])); e.r_hi = pwm_hi(n, int'(rgb[23:16]));
        e.g_lo = pwm_lo(n, int'(rgb[15:8]));  e.g_hi = pwm_hi(n, int'(rgb[15:8]));
        e.b_lo = pwm_lo(n, int'(rgb[7:0]));   e.b_hi = pwm_hi(n, int'(rgb[7:0]));
        exp_q.push_back(e);
    endtask

    // Monitor: records one observation per command, from handshake until busy falls.
    obs_t cur;
    bit   in_cmd = 0, prev_busy = 0;
    int   idle_run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_cmd = 0; prev_busy = 0; idle_run = 0;
        end else begin
            if (prev_busy && !busy && in_cmd) begin
                obs_q.push_back(cur);
                in_cmd = 0;
            end
            if (busy) begin
                idle_run = 0;
                cur.busy_len++;
                cur.red += int'(red_pwm); cur.green += int'(green_pwm); cur.blue += int'(blue_pwm);
            end else begin
                idle_run++;
                if (red_pwm || green_pwm || blue_pwm) stray_pwm++;
            end
            if (a_ready && b_ready) both_ready++;
            if (busy && (a_ready || b_ready)) ready_busy++;
            if ((a_valid && a_ready) || (b_valid && b_ready)) begin
                hs_count++;
                cur.owner = b_valid && b_ready;
                cur.rgb = (b_valid && b_ready) ? b_rgb : a_rgb;
                cur.busy_len = 0; cur.red = 0; cur.green = 0; cur.blue = 0;
                cur.idle_before = idle_run;
                in_cmd = 1;
            end
            prev_busy = busy;
        end
    end

    // Present one command; with keep set the valid stays high so the next call follows immediately.
    task automatic send(input bit side, input logic [23:0] rgb, input logic [15:0] dur, input bit keep);
        bit got = 0;
        if (!(side ? b_valid : a_valid)) begin
            @(posedge clk); #1;
        end
        if (side) begin b_valid = 1; b_rgb = rgb; b_dur_ms = dur; end
        else      begin a_valid = 1; a_rgb = rgb; a_dur_ms = dur; end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (side ? b_ready : a_ready) begin got = 1; break; end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout side=%0d: ready never seen, required within 3000 cycles", side);
        end
        @(posedge clk); #1;
        if (!keep) begin
            if (side) b_valid = 0; else a_valid = 0;
        end
    endtask

    task automatic wait_obs(output bit ok);
        int w = 0;
        while (obs_q.size() == 0 && w < 3000) begin @(negedge clk); w++; end
        ok = (obs_q.size() != 0);
    endtask

    task automatic test_reset();
        rst_n = 0; a_valid = 0; b_valid = 0;
        a_rgb = '0; b_rgb = '0; a_dur_ms = '0; b_dur_ms = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (grant_b !== 1'b1) begin n_fail++; $display("FAIL reset_grant_b: got %b want 1", grant_b); end
        n_checks++; if ({red_pwm, green_pwm, blue_pwm} !== 3'b000) begin n_fail++; $display("FAIL reset_pwm: got %b want 000", {red_pwm, green_pwm, blue_pwm}); end
        n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready}); end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_single_a();
        exp_t e; obs_t o; bit ok;
        int   hs0 = hs_count;
        push_exp(0, RGB_RED, 3, 0);
        send(0, RGB_RED, 16'd3, 0);
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            e = exp_q.pop_front();
            if (!ok) begin n_checks++; n_fail++; $display("FAIL single_a_timeout: no command end seen"); break; end
            o = obs_q.pop_front();
            n_checks++; if (o.owner !== e.owner) begin n_fail++; $display("FAIL single_a_owner: got %0d want %0d", o.owner, e.owner); end
            n_checks++; if (o.busy_len !== e.busy_len) begin n_fail++; $display("FAIL single_a_busy_len: got %0d want %0d", o.busy_len, e.busy_len); end
            n_checks++; if (o.red < e.r_lo || o.red > e.r_hi) begin n_fail++; $display("FAIL single_a_red: got %0d want %0d..%0d", o.red, e.r_lo, e.r_hi); end
            n_checks++; if (o.green + o.blue !== 0) begin n_fail++; $display("FAIL single_a_green_blue: got %0d want 0", o.green + o.blue); end
        end
        n_checks++; if (hs_count - hs0 !== 1) begin n_fail++; $display("FAIL single_a_ready_pulses: got %0d want 1", hs_count - hs0); end
        n_checks++; if (grant_b !== 1'b0) begin n_fail++; $display("FAIL single_a_grant_b: got %b want 0", grant_b); end
    endtask

    task automatic test_dur_and_window();
        exp_t e; obs_t o; bit ok;
        push_exp(0, 24'h800040, 0, 0);
        push_exp(1, 24'h800040, 64, 0);
        send(0, 24'h800040, 16'd0, 0);
        send(1, 24'h800040, 16'd64, 0);
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            e = exp_q.pop_front();
            if (!ok) begin n_checks++; n_fail++; $display("FAIL window_timeout: no command end seen"); break; end
            o = obs_q.pop_front();
            n_checks++; if (o.owner !== e.owner) begin n_fail++; $display("FAIL window_owner: got %0d want %0d", o.owner, e.owner); end
            n_checks++; if (o.busy_len !== e.busy_len) begin n_fail++; $display("FAIL window_busy_len: got %0d want %0d", o.busy_len, e.busy_len); end
            n_checks++; if (o.red < e.r_lo || o.red > e.r_hi) begin n_fail++; $display("FAIL window_red: got %0d want %0d..%0d", o.red, e.r_lo, e.r_hi); end
            n_checks++; if (o.green < e.g_lo || o.green > e.g_hi) begin n_fail++; $display("FAIL window_green: got %0d want %0d..%0d", o.green, e.g_lo, e.g_hi); end
            n_checks++; if (o.blue < e.b_lo || o.blue > e.b_hi) begin n_fail++; $display("FAIL window_blue: got %0d want %0d..%0d", o.blue, e.b_lo, e.b_hi); end
        end
    endtask

    task automatic test_round_robin();
        exp_t e; obs_t o; bit ok;
        test_reset();
        push_exp(0, RGB_GREEN, 1, 0);
        push_exp(1, RGB_WHITE, 2, 1);
        push_exp(0, RGB_BLUE, 1, 1);
        fork
            begin send(0, RGB_GREEN, 16'd1, 1); send(0, RGB_BLUE, 16'd1, 0); end
            begin send(1, RGB_WHITE, 16'd2, 0); end
        join
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            e = exp_q.pop_front();
            if (!ok) begin n_checks++; n_fail++; $display("FAIL rr_timeout: no command end seen"); break; end
            o = obs_q.pop_front();
            n_checks++; if (o.owner !== e.owner) begin n_fail++; $display("FAIL rr_owner: got %0d want %0d", o.owner, e.owner); end
            n_checks++; if (o.rgb !== e.rgb) begin n_fail++; $display("FAIL rr_rgb: got %h want %h", o.rgb, e.rgb); end
            n_checks++; if (o.busy_len !== e.busy_len) begin n_fail++; $display("FAIL rr_busy_len: got %0d want %0d", o.busy_len, e.busy_len); end
            if (e.chk_idle) begin
                n_checks++; if (o.idle_before !== 1) begin n_fail++; $display("FAIL rr_idle_gap: got %0d want 1", o.idle_before); end
            end
        end
    endtask

    task automatic test_hold_during_show();
        exp_t e; obs_t o; bit ok;
        int   hs0 = hs_count;
        push_exp(0, RGB_GREEN, 5, 0);
        push_exp(0, RGB_BLUE, 1, 1);
        send(0, RGB_GREEN, 16'd5, 1);
        send(0, RGB_BLUE, 16'd1, 0);
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            e = exp_q.pop_front();
            if (!ok) begin n_checks++; n_fail++; $display("FAIL hold_timeout: no command end seen"); break; end
            o = obs_q.pop_front();
            n_checks++; if (o.rgb !== e.rgb) begin n_fail++; $display("FAIL hold_rgb: got %h want %h", o.rgb, e.rgb); end
            n_checks++; if (o.blue < e.b_lo || o.blue > e.b_hi) begin n_fail++; $display("FAIL hold_blue: got %0d want %0d..%0d", o.blue, e.b_lo, e.b_hi); end
            if (e.chk_idle) begin
                n_checks++; if (o.idle_before !== 1) begin n_fail++; $display("FAIL hold_idle_gap: got %0d want 1", o.idle_before); end
            end
        end
        repeat (20) @(negedge clk);
        n_checks++; if (hs_count - hs0 !== 2) begin n_fail++; $display("FAIL hold_accept_count: got %0d want 2", hs_count - hs0); end
    endtask

    task automatic test_reset_mid_show();
        exp_t e; obs_t o; bit ok;
        send(0, RGB_WHITE, 16'd10, 0);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        #1 rst_n = 0;
        #1;
        n_checks++; if ({busy, red_pwm, green_pwm, blue_pwm} !== 4'b0000) begin n_fail++; $display("FAIL abort_outputs: got %b want 0000", {busy, red_pwm, green_pwm, blue_pwm}); end
        n_checks++; if (grant_b !== 1'b1) begin n_fail++; $display("FAIL abort_grant_b: got %b want 1", grant_b); end
        @(posedge clk); #1;
        rst_n = 1;
        obs_q.delete();
        push_exp(0, 24'hFF00FF, 2, 0);
        send(0, 24'hFF00FF, 16'd2, 0);
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            e = exp_q.pop_front();
            if (!ok) begin n_checks++; n_fail++; $display("FAIL post_abort_timeout: no command end seen"); break; end
            o = obs_q.pop_front();
            n_checks++; if (o.rgb !== e.rgb) begin n_fail++; $display("FAIL post_abort_rgb: got %h want %h", o.rgb, e.rgb); end
            n_checks++; if (o.busy_len !== e.busy_len) begin n_fail++; $display("FAIL post_abort_busy_len: got %0d want %0d", o.busy_len, e.busy_len); end
            n_checks++; if (o.red < e.r_lo || o.red > e.r_hi) begin n_fail++; $display("FAIL post_abort_red: got %0d want %0d..%0d", o.red, e.r_lo, e.r_hi); end
        end
    endtask

    task automatic test_hygiene();
        n_checks++; if (stray_pwm !== 0) begin n_fail++; $display("FAIL pwm_outside_busy: got %0d want 0", stray_pwm); end
        n_checks++; if (both_ready !== 0) begin n_fail++; $display("FAIL both_ready: got %0d want 0", both_ready); end
        n_checks++; if (ready_busy !== 0) begin n_fail++; $display("FAIL ready_while_busy: got %0d want 0", ready_busy); end
    endtask

    initial begin
        rst_n = 0; a_valid = 0; b_valid = 0;
        test_reset();
        test_single_a();
        test_dur_and_window();
        test_round_robin();
        test_hold_during_show();
        test_reset_mid_show();
        test_hygiene();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded 40000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
